// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline hazard signals between the controller (master) and the datapath (slave)
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [3:0] decRa1, decRa2, exeRa1, exeRa2, exeWa, memWa, wbWa;
    logic exeMemToReg, memRegWrite, wbRegWrite, exePcSrc, memBusy, haltReq;
    logic haltAck, stallF, stallD, stallE, stallM, flushD, flushE;
    logic [1:0] fwdA, fwdB;
    logic [CNT_W-1:0] stallCycles, redirectCount;
    modport master (
        input decRa1, decRa2, exeRa1, exeRa2, exeWa, exeMemToReg, memWa, memRegWrite,
        input wbWa, wbRegWrite, exePcSrc, memBusy, haltReq,
        output haltAck, stallF, stallD, stallE, stallM, flushD, flushE, fwdA, fwdB,
        output stallCycles, redirectCount
    );
    modport slave (
        output decRa1, decRa2, exeRa1, exeRa2, exeWa, exeMemToReg, memWa, memRegWrite,
        output wbWa, wbRegWrite, exePcSrc, memBusy, haltReq,
        input haltAck, stallF, stallD, stallE, stallM, flushD, flushE, fwdA, fwdB,
        input stallCycles, redirectCount
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control, halt grant and saturating perf counters
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    pipe_hazard_ctrl_if.master hz
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
    localparam logic [2:0] FC_M1 = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX = '1;
    state_t state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic load_use, stall_all, stall_fd, flush_d, flush_e, redirect, halt_ack;
    logic [CNT_W-1:0] stall_cnt, redir_cnt;
    function automatic logic [1:0] fwd(input logic [3:0] ra, input logic [3:0] mwa, input logic mrw,
                                       input logic [3:0] wwa, input logic wrw);
        return (ra == 4'd15) ? 2'b00 : (mrw && mwa == ra) ? 2'b10 : (wrw && wwa == ra) ? 2'b01 : 2'b00;
    endfunction
    assign load_use = hz.exeMemToReg && hz.exeWa != 4'd15 && (hz.exeWa == hz.decRa1 || hz.exeWa == hz.decRa2);
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        stall_all = 1'b0;
        stall_fd = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        redirect = 1'b0;
        case (state)
            RUN: begin
                if (hz.memBusy) stall_all = 1'b1;
                else if (hz.exePcSrc) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    redirect = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nx = FLUSH;
                        cnt_nx = FC_M1;
                    end
                end else if (load_use) begin
                    stall_fd = 1'b1;
                    flush_e = 1'b1;
                end else if (hz.haltReq) state_nx = HALT;
            end
            FLUSH: begin
                if (hz.memBusy) stall_all = 1'b1;
                else begin
                    flush_d = 1'b1;
                    cnt_nx = cnt - 3'd1;
                    if (cnt == 3'd1) state_nx = RUN;
                end
            end
            HALT: begin
                stall_all = 1'b1;
                if (!hz.haltReq) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt <= 3'd0;
            halt_ack <= 1'b0;
            stall_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            halt_ack <= state_nx == HALT;
            if ((stall_all || stall_fd) && stall_cnt != MAX) stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect && redir_cnt != MAX) redir_cnt <= redir_cnt + CNT_W'(1);
        end
    end
    assign hz.stallF = stall_all || stall_fd;
    assign hz.stallD = stall_all || stall_fd;
    assign hz.stallE = stall_all;
    assign hz.stallM = stall_all;
    assign hz.flushD = flush_d;
    assign hz.flushE = flush_e;
    assign hz.haltAck = halt_ack;
    assign hz.stallCycles = stall_cnt;
    assign hz.redirectCount = redir_cnt;
    assign hz.fwdA = fwd(hz.exeRa1, hz.memWa, hz.memRegWrite, hz.wbWa, hz.wbRegWrite);
    assign hz.fwdB = fwd(hz.exeRa2, hz.memWa, hz.memRegWrite, hz.wbWa, hz.wbRegWrite);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int FC = 2;
    localparam int CW = 16;
    localparam int SAT = 65535;
    logic clk = 1'b0;
    logic rst;
    logic chk_en = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int flush_left = 0;
    bit halted = 1'b0;
    int stall_cnt = 0;
    int redir_cnt = 0;
    int fd_count;
    pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();
    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .hz(hz));
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fwd_exp(input logic [3:0] ra);
        if (ra == 4'd15) return 0;
        if (hz.memRegWrite && hz.memWa == ra) return 2;
        if (hz.wbRegWrite && hz.wbWa == ra) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            bit lu, busy, free, take, e_all, e_ld, e_fd, e_fe;
            lu = hz.exeMemToReg && hz.exeWa != 4'd15 && (hz.exeWa == hz.decRa1 || hz.exeWa == hz.decRa2);
            busy = hz.memBusy;
            free = !halted && !busy;
            take = free && flush_left == 0 && hz.exePcSrc;
            e_all = halted || busy;
            e_fd = free && (flush_left > 0 || hz.exePcSrc);
            e_fe = free && flush_left == 0 && (hz.exePcSrc || lu);
            e_ld = free && flush_left == 0 && !hz.exePcSrc && lu;
            check("stallF", 32'(hz.stallF), 32'(e_all || e_ld));
            check("stallD", 32'(hz.stallD), 32'(e_all || e_ld));
            check("stallE", 32'(hz.stallE), 32'(e_all));
            check("stallM", 32'(hz.stallM), 32'(e_all));
            check("flushD", 32'(hz.flushD), 32'(e_fd));
            check("flushE", 32'(hz.flushE), 32'(e_fe));
            check("fwdA", 32'(hz.fwdA), 32'(fwd_exp(hz.exeRa1)));
            check("fwdB", 32'(hz.fwdB), 32'(fwd_exp(hz.exeRa2)));
            check("haltAck", 32'(hz.haltAck), 32'(halted));
            check("stallCycles", 32'(hz.stallCycles), 32'(stall_cnt));
            check("redirectCount", 32'(hz.redirectCount), 32'(redir_cnt));
            if (rst) begin
                halted = 1'b0;
                flush_left = 0;
                stall_cnt = 0;
                redir_cnt = 0;
            end else begin
                if (e_all || e_ld) stall_cnt = (stall_cnt < SAT) ? stall_cnt + 1 : SAT;
                if (take) redir_cnt = (redir_cnt < SAT) ? redir_cnt + 1 : SAT;
                if (halted) halted = hz.haltReq;
                else if (flush_left > 0) begin
                    if (!busy) flush_left--;
                end else if (take) flush_left = FC - 1;
                else if (free && !lu && hz.haltReq) halted = 1'b1;
            end
        end
    end

    task automatic idle();
        hz.decRa1 = 4'd1; hz.decRa2 = 4'd2; hz.exeRa1 = 4'd0; hz.exeRa2 = 4'd0;
        hz.exeWa = 4'd0; hz.exeMemToReg = 1'b0; hz.memWa = 4'd0; hz.memRegWrite = 1'b0;
        hz.wbWa = 4'd0; hz.wbRegWrite = 1'b0; hz.exePcSrc = 1'b0; hz.memBusy = 1'b0; hz.haltReq = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_haltAck", 32'(hz.haltAck), 32'd0);
        check("rst_stallCycles", 32'(hz.stallCycles), 32'd0);
        check("rst_redirect", 32'(hz.redirectCount), 32'd0);
        nxt();
        hz.exeMemToReg = 1'b1; hz.exeWa = 4'd3; hz.decRa2 = 4'd3;
        @(negedge clk);
        check("lu_stallF", 32'(hz.stallF), 32'd1);
        check("lu_stallD", 32'(hz.stallD), 32'd1);
        check("lu_flushE", 32'(hz.flushE), 32'd1);
        nxt();
        idle();
        @(negedge clk);
        check("lu_after_stallD", 32'(hz.stallD), 32'd0);
        check("lu_stallCycles", 32'(hz.stallCycles), 32'd1);
        nxt();
        hz.exePcSrc = 1'b1;
        @(negedge clk);
        check("br0_flushD", 32'(hz.flushD), 32'd1);
        check("br0_flushE", 32'(hz.flushE), 32'd1);
        nxt();
        idle();
        @(negedge clk);
        check("br1_flushD", 32'(hz.flushD), 32'd1);
        check("br1_flushE", 32'(hz.flushE), 32'd0);
        nxt();
        @(negedge clk);
        check("br2_flushD", 32'(hz.flushD), 32'd0);
        check("br2_redirect", 32'(hz.redirectCount), 32'd1);
        nxt();
        hz.memWa = 4'd5; hz.wbWa = 4'd5; hz.memRegWrite = 1'b1; hz.wbRegWrite = 1'b1;
        hz.exeRa1 = 4'd5; hz.exeRa2 = 4'd15;
        @(negedge clk);
        check("fwd_memA", 32'(hz.fwdA), 32'd2);
        check("fwd_pcB", 32'(hz.fwdB), 32'd0);
        nxt();
        hz.memRegWrite = 1'b0;
        @(negedge clk);
        check("fwd_wbA", 32'(hz.fwdA), 32'd1);
        nxt();
        idle();
        hz.haltReq = 1'b1;
        @(negedge clk);
        check("halt_req_ack", 32'(hz.haltAck), 32'd0);
        nxt();
        @(negedge clk);
        check("halt_ack", 32'(hz.haltAck), 32'd1);
        check("halt_stallM", 32'(hz.stallM), 32'd1);
        nxt();
        hz.haltReq = 1'b0;
        @(negedge clk);
        check("halt_drop_ack", 32'(hz.haltAck), 32'd1);
        nxt();
        @(negedge clk);
        check("halt_rel_ack", 32'(hz.haltAck), 32'd0);
        check("halt_rel_stallF", 32'(hz.stallF), 32'd0);
        fd_count = 0;
        nxt();
        hz.exePcSrc = 1'b1;
        @(negedge clk);
        fd_count += int'(hz.flushD);
        nxt();
        hz.exePcSrc = 1'b0;
        hz.memBusy = 1'b1;
        @(negedge clk);
        fd_count += int'(hz.flushD);
        check("fbusy_stallF", 32'(hz.stallF), 32'd1);
        check("fbusy_stallM", 32'(hz.stallM), 32'd1);
        check("fbusy_flushD", 32'(hz.flushD), 32'd0);
        nxt();
        hz.memBusy = 1'b0;
        @(negedge clk);
        fd_count += int'(hz.flushD);
        check("fresume_flushD", 32'(hz.flushD), 32'd1);
        nxt();
        @(negedge clk);
        fd_count += int'(hz.flushD);
        check("flushD_total", 32'(fd_count), 32'd2);
        check("redirect_two", 32'(hz.redirectCount), 32'd2);
        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst = ($urandom_range(0, 149) == 0);
            hz.decRa1 = 4'($urandom_range(0, 7)); hz.decRa2 = 4'($urandom_range(0, 7));
            hz.exeRa1 = 4'($urandom_range(0, 7)); hz.exeRa2 = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
            hz.exeWa = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
            hz.memWa = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
            hz.wbWa = 4'($urandom_range(0, 7));
            hz.exeMemToReg = ($urandom_range(0, 2) == 0);
            hz.memRegWrite = $urandom_range(0, 1) == 1;
            hz.wbRegWrite = $urandom_range(0, 1) == 1;
            hz.exePcSrc = ($urandom_range(0, 7) == 0);
            hz.memBusy = ($urandom_range(0, 5) == 0);
            hz.haltReq = ($urandom_range(0, 3) == 0);
        end
        nxt();
        idle();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        hz.memBusy = 1'b1;
        repeat (65540) nxt();
        @(negedge clk);
        check("sat_stallCycles", 32'(hz.stallCycles), 32'hFFFF);
        nxt();
        hz.memBusy = 1'b0;
        hz.haltReq = 1'b1;
        nxt();
        @(negedge clk);
        check("sat_halt_ack", 32'(hz.haltAck), 32'd1);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        check("sat_pre_rst_ack", 32'(hz.haltAck), 32'd1);
        nxt();
        rst = 1'b0;
        hz.haltReq = 1'b0;
        @(negedge clk);
        check("rst_halt_ack", 32'(hz.haltAck), 32'd0);
        check("rst_halt_cnt", 32'(hz.stallCycles), 32'd0);
        check("rst_halt_stallF", 32'(hz.stallF), 32'd0);
        nxt();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
